// File: rtl/fp_pkg.sv
// Shared floating-point format defaults, derived constants and the divider FSM state type.
package fp_pkg;

  localparam int FP_EXP_WIDTH      = 8;
  localparam int FP_MANTISSA_WIDTH = 23;
  localparam int FP_BIAS           = 2**(FP_EXP_WIDTH-1) - 1;

  // Largest finite magnitude {exp = all-ones - 1, frac = all-ones}, sign excluded.
  localparam logic [FP_EXP_WIDTH+FP_MANTISSA_WIDTH-1:0] FP_MAX_MAG =
    {{(FP_EXP_WIDTH-1){1'b1}}, 1'b0, {FP_MANTISSA_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORMALIZE,
    DONE
  } fpd_state_t;

endpackage

// File: rtl/fpd_mantissa_divider.sv
// Restoring divider for 1.fa / 1.fb: one quotient bit per step, MANTISSA_WIDTH+2 steps.
module fpd_mantissa_divider #(
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_load,
  input  logic                      i_step,
  input  logic [MANTISSA_WIDTH:0]   i_dividend,
  input  logic [MANTISSA_WIDTH:0]   i_divisor,
  output logic [MANTISSA_WIDTH+1:0] o_quotient,
  output logic                      o_last
);

  localparam int M  = MANTISSA_WIDTH;
  localparam int CW = $clog2(M + 2);

  logic [M+1:0]  r_rem;
  logic [M+1:0]  r_quot;
  logic [M:0]    r_div;
  logic [CW-1:0] r_count;

  logic          w_ge;
  logic [M+1:0]  w_diff;

  // The remainder stays below twice the divisor, so its top bit is always
  // zero after a step and the left shift never loses information.
  always_comb begin
    w_ge   = (r_rem >= {1'b0, r_div});
    w_diff = r_rem - {1'b0, r_div};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem   <= '0;
      r_quot  <= '0;
      r_div   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_rem   <= {1'b0, i_dividend};
      r_div   <= i_divisor;
      r_quot  <= '0;
      r_count <= '0;
    end else if (i_step) begin
      r_quot <= {r_quot[M:0], w_ge};
      r_rem  <= w_ge ? {w_diff[M:0], 1'b0} : {r_rem[M:0], 1'b0};
      if (!o_last) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  always_comb begin
    o_quotient = r_quot;
    o_last     = (r_count == CW'(M + 1));
  end

endmodule

// File: rtl/fp_divider.sv
// Sequential floating-point divider: FSM, sign/exponent path, special cases and output registers.
module fp_divider
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH      = FP_EXP_WIDTH,
  parameter int MANTISSA_WIDTH = FP_MANTISSA_WIDTH
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                start_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   b_in,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   fpd_out,
  output logic                                overflow_out,
  output logic                                underflow_out,
  output logic                                div_by_zero_out,
  output logic                                busy_out,
  output logic                                done_out
);

  localparam int M   = MANTISSA_WIDTH;
  localparam int W   = 1 + EXP_WIDTH + M;
  localparam int EW2 = EXP_WIDTH + 2;
  localparam logic signed [EW2-1:0] BIAS = EW2'(2**(EXP_WIDTH-1) - 1);
  localparam logic signed [EW2-1:0] EMAX = EW2'(2**EXP_WIDTH - 1);
  localparam logic [W-2:0] MAX_MAG = {{(EXP_WIDTH-1){1'b1}}, 1'b0, {M{1'b1}}};

  fpd_state_t r_state, w_next;

  logic                 r_sign;
  logic [EXP_WIDTH-1:0] r_ea;
  logic [EXP_WIDTH-1:0] r_eb;

  logic [W-1:0] r_fpd;
  logic         r_ovf;
  logic         r_unf;
  logic         r_dbz;

  logic         w_load;
  logic         w_step;
  logic         w_last;
  logic [M+1:0] w_quot;

  logic signed [EW2-1:0] w_exp_raw;
  logic signed [EW2-1:0] w_exp;
  logic [M-1:0]          w_frac;
  logic [W-1:0]          w_res;
  logic                  w_ovf;
  logic                  w_unf;
  logic                  w_dbz;

  always_comb begin
    w_load = (r_state == IDLE) && start_in;
    w_step = (r_state == DIVIDE);
  end

  fpd_mantissa_divider #(
    .MANTISSA_WIDTH(M)
  ) u_mant (
    .i_clk      (clk_in),
    .i_rst      (rst_in),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend ({1'b1, a_in[M-1:0]}),
    .i_divisor  ({1'b1, b_in[M-1:0]}),
    .o_quotient (w_quot),
    .o_last     (w_last)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (start_in) w_next = DIVIDE;
      DIVIDE:    if (w_last)   w_next = NORMALIZE;
      NORMALIZE: w_next = DONE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sign <= 1'b0;
      r_ea   <= '0;
      r_eb   <= '0;
    end else if (w_load) begin
      r_sign <= a_in[W-1] ^ b_in[W-1];
      r_ea   <= a_in[W-2:M];
      r_eb   <= b_in[W-2:M];
    end
  end

  // Quotient lies in (0.5, 2): a clear integer bit means one extra shift and
  // the fraction is taken one position lower, with the exponent decremented.
  always_comb begin
    w_exp_raw = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + BIAS;
    if (w_quot[M+1]) begin
      w_exp  = w_exp_raw;
      w_frac = w_quot[M:1];
    end else begin
      w_exp  = w_exp_raw - EW2'(1);
      w_frac = w_quot[M-1:0];
    end
  end

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_dbz = 1'b0;
    if (r_eb == '0) begin
      w_dbz = 1'b1;
      w_res = {r_sign, MAX_MAG};
    end else if (r_ea == '0) begin
      w_res = {r_sign, {(W-1){1'b0}}};
    end else if (w_exp >= EMAX) begin
      w_ovf = 1'b1;
      w_res = {r_sign, MAX_MAG};
    end else if (w_exp[EW2-1] || (w_exp == '0)) begin
      w_unf = 1'b1;
      w_res = {r_sign, {(W-1){1'b0}}};
    end else begin
      w_res = {r_sign, w_exp[EXP_WIDTH-1:0], w_frac};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fpd <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_dbz <= 1'b0;
    end else if (r_state == NORMALIZE) begin
      r_fpd <= w_res;
      r_ovf <= w_ovf;
      r_unf <= w_unf;
      r_dbz <= w_dbz;
    end
  end

  always_comb begin
    fpd_out         = r_fpd;
    overflow_out    = r_ovf;
    underflow_out   = r_unf;
    div_by_zero_out = r_dbz;
    busy_out        = (r_state != IDLE);
    done_out        = (r_state == DONE);
  end

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider (single precision): directed vectors, random operands, handshake and reset abort.
module tb_fp_divider;

  localparam int E = 8;
  localparam int M = 23;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] fpd;
  logic        ovf;
  logic        unf;
  logic        dbz;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  fp_divider #(
    .EXP_WIDTH(E),
    .MANTISSA_WIDTH(M)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .start_in        (start),
    .a_in            (a),
    .b_in            (b),
    .fpd_out         (fpd),
    .overflow_out    (ovf),
    .underflow_out   (unf),
    .div_by_zero_out (dbz),
    .busy_out        (busy),
    .done_out        (done)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        dbz;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: exact integer quotient of the significands, truncated.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    logic [63:0] na, nb, q;
    logic [22:0] frac;
    int          e;
    logic        s;
    r.res = '0; r.ovf = 1'b0; r.unf = 1'b0; r.dbz = 1'b0; r.start_cyc = 0;
    s = x[31] ^ y[31];
    if (y[30:23] == 8'd0) begin
      r.dbz = 1'b1;
      r.res = {s, 8'hFE, 23'h7FFFFF};
    end else if (x[30:23] == 8'd0) begin
      r.res = {s, 31'd0};
    end else begin
      na = {40'd0, 1'b1, x[22:0]};
      nb = {40'd0, 1'b1, y[22:0]};
      q  = (na << 24) / nb;
      e  = int'(x[30:23]) - int'(y[30:23]) + 127;
      if (q < 64'h100_0000) begin
        e--;
        frac = q[22:0];
      end else begin
        frac = q[23:1];
      end
      if (e >= 255) begin
        r.ovf = 1'b1;
        r.res = {s, 8'hFE, 23'h7FFFFF};
      end else if (e <= 0) begin
        r.unf = 1'b1;
        r.res = {s, 31'd0};
      end else begin
        r.res = {s, 8'(e), frac};
      end
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [31:0] res, input logic [2:0] fl);
    exp_t r;
    r.res = res; r.ovf = fl[2]; r.unf = fl[1]; r.dbz = fl[0]; r.start_cyc = 0;
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] ex;
    ex = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done_out=1 at cycle %0d expected no completion", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("result", 64'(fpd), 64'(mon_e.res));
          check("flags_ovf_unf_dbz", 64'({ovf, unf, dbz}), 64'({mon_e.ovf, mon_e.unf, mon_e.dbz}));
          check("latency", 64'(cyc - mon_e.start_cyc), 64'(M + 3));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit push,
                       input exp_t ex, output int s);
    int   guard;
    exp_t e;
    guard = 0;
    e = ex;
    @(negedge clk);
    while (busy && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("idle_before_start", 64'(busy), 64'(0));
    a = x;
    b = y;
    start = 1'b1;
    s = cyc + 1;
    if (push) begin
      e.start_cyc = s;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done();
    bit seen;
    bit busy_ok;
    seen = 1'b0;
    busy_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(seen), 64'(1));
    check("busy_high", 64'(busy_ok), 64'(1));
  endtask

  task automatic run_one(input logic [31:0] x, input logic [31:0] y, input exp_t ex);
    int s;
    issue(x, y, 1'b1, ex, s);
    wait_done();
  endtask

  logic [31:0] dir_a   [10] = '{32'h40C00000, 32'h3F800000, 32'hC0F00000, 32'h00000000, 32'h3F800000,
                                32'h7F000000, 32'h00800000, 32'hC0000000, 32'h40000000, 32'h80000000};
  logic [31:0] dir_b   [10] = '{32'h40000000, 32'h40400000, 32'h40200000, 32'h40000000, 32'h00000000,
                                32'h3E800000, 32'h40000000, 32'h00000000, 32'hC0000000, 32'hBF800000};
  logic [31:0] dir_res [10] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0400000, 32'h00000000, 32'h7F7FFFFF,
                                32'h7F7FFFFF, 32'h00000000, 32'hFF7FFFFF, 32'hBF800000, 32'h00000000};
  logic [2:0]  dir_fl  [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001,
                                3'b100, 3'b010, 3'b001, 3'b000, 3'b000};

  initial begin
    int          s;
    logic [31:0] x, y;
    exp_t        dummy;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    dummy = mk(32'd0, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({fpd, ovf, unf, dbz, busy, done}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_one(dir_a[i], dir_b[i], mk(dir_res[i], dir_fl[i]));
      if (i == 0) begin
        repeat (5) @(negedge clk);
        check("result_held", 64'({fpd, ovf, unf, dbz, busy}), 64'({32'h40400000, 4'b0000}));
      end
    end

    for (int i = 0; i < 40; i++) begin
      x = rand_fp();
      y = rand_fp();
      run_one(x, y, model(x, y));
    end

    // Starts during a busy operation, including the DONE cycle, are ignored.
    x = 32'h41200000;
    y = 32'h40800000;
    issue(x, y, 1'b1, mk(32'h40200000, 3'b000), s);
    for (int k = 0; k < 30; k++) begin
      int rel;
      rel = cyc + 1 - s;
      start = (rel == 5) || (rel == 26) || (rel == 27);
      if (start) begin
        a = rand_fp();
        b = rand_fp();
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("ignored_start_pending", 64'(sb.size()), 64'(0));

    // Reset mid-operation aborts it with no completion pulse.
    issue(32'h40C00000, 32'h40000000, 1'b0, dummy, s);
    while (cyc + 1 - s < 10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_abort_outputs", 64'({fpd, ovf, unf, dbz, busy, done}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (35) @(negedge clk);
    check("reset_abort_idle", 64'({busy, fpd}), 64'(0));

    run_one(32'h40C00000, 32'h40000000, mk(32'h40400000, 3'b000));
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
